aib_avmm_cmd_seq: RTL and testbench
===================================

AIB_AVMM_CMD_SEQ -- requirements
Module: aib_avmm_cmd_seq

Interface
REQ-001 Parameter NUM_CHNL, default 24: number of addressable AIB channels.
REQ-002 Parameter CHNL_W, default 6: channel-id width; SHALL satisfy 2**CHNL_W >= NUM_CHNL.
REQ-003 Parameter ADDR_W, default 17: AVMM address width.
REQ-004 Parameter CMD_DEPTH, default 4: command FIFO depth; power of 2, >= 2.
REQ-005 Parameter TIMEOUT_CYC, default 256: maximum cycles in ISSUE or WAIT_RD before abort.
REQ-006 Clocking: one clock; reset is synchronous and active-low.
REQ-007 Port i_cfg_avmm_clk, input, 1: sole clock.
REQ-008 Port i_cfg_avmm_rst_n, input, 1: synchronous active-low reset.
REQ-009 Ports i_cmd_valid in 1 and o_cmd_ready out 1: command push handshake.
REQ-010 Ports i_cmd_write in 1, i_cmd_chnl in CHNL_W, i_cmd_addr in ADDR_W, i_cmd_byte_en in 4, i_cmd_wdata in 32: command fields.
REQ-011 Ports o_rsp_valid out 1, o_rsp_chnl out CHNL_W, o_rsp_rdata out 32, o_rsp_write out 1, o_rsp_timeout out 1: one-cycle response.
REQ-012 Ports o_channel_id out CHNL_W, o_cfg_avmm_addr out ADDR_W, o_cfg_avmm_byte_en out 4, o_cfg_avmm_read out 1, o_cfg_avmm_write out 1, o_cfg_avmm_wdata out 32: AVMM master.
REQ-013 Ports i_cfg_avmm_waitreq in 1, i_cfg_avmm_rdatavld in 1, i_cfg_avmm_rdata in 32: AVMM slave return.
REQ-014 Port o_busy out 1: high when FIFO non-empty or state != IDLE.

Function
REQ-015 o_cmd_ready = !fifo_full; push occurs on an edge with i_cmd_valid && o_cmd_ready; push while full SHALL be dropped with no state change.
REQ-016 Simultaneous push and pop SHALL both take effect; occupancy unchanged; pointers wrap modulo CMD_DEPTH.
REQ-017 FSM states IDLE, ISSUE, WAIT_RD, RSP; all transitions on i_cfg_avmm_clk rising edge.
REQ-018 IDLE -> ISSUE when FIFO non-empty; head is popped into a command register on that edge.
REQ-019 In ISSUE, o_cfg_avmm_read = !write, o_cfg_avmm_write = write, and addr/byte_en/wdata/o_channel_id driven from the command register, held stable until accepted.
REQ-020 Command accepted on the edge where i_cfg_avmm_waitreq is sampled low in ISSUE; write -> RSP, read -> WAIT_RD.
REQ-021 WAIT_RD -> RSP on the edge where i_cfg_avmm_rdatavld is sampled high; i_cfg_avmm_rdata captured into o_rsp_rdata.
REQ-022 RSP lasts exactly one cycle with o_rsp_valid=1, then -> IDLE; writes report o_rsp_rdata=0.
REQ-023 Latency: push edge N into empty idle block -> read/write first asserted in cycle after edge N+1; o_rsp_valid high in cycle after accept edge (write) or rdatavld edge (read).
REQ-024 Timeout counter clears on entry to ISSUE, runs through ISSUE and WAIT_RD; at TIMEOUT_CYC-th cycle without completion -> RSP with o_rsp_timeout=1, o_rsp_rdata=32'hFFFF_FFFF, read/write deasserted.
REQ-025 i_cfg_avmm_rdatavld outside WAIT_RD SHALL be ignored.
REQ-026 i_cmd_chnl >= NUM_CHNL SHALL bypass the bus: response returned with o_rsp_timeout=1 and rdata all ones, one cycle after pop.
REQ-027 o_rsp_chnl and o_rsp_write SHALL equal the command register fields during RSP.

Reset
REQ-028 While i_cfg_avmm_rst_n low on an edge: FSM=IDLE, FIFO empty, timeout counter 0, every output 0 except o_cmd_ready, which reads 1 the cycle after reset.
REQ-029 Reset mid-transaction SHALL abort without emitting a response; in-flight and queued commands are discarded.

Structure
REQ-030 Package aib_avmm_pkg: FSM state enum, command struct, DATA_W=32, BE_W=4 constants.
REQ-031 Sub-module aib_sync_fifo (parametrised width/depth, synchronous active-low reset) implements the command FIFO.

Verification
REQ-032 Write chnl 3 addr 0x00208 data 0xA5A5_0001, waitreq low -> write pulse 1 cycle, rsp_valid chnl 3 rdata 0 timeout 0.
REQ-033 Read chnl 5 addr 0x00300, waitreq high 3 cycles, rdatavld 2 cycles after accept with 0x1234_5678 -> read held 4 cycles, rsp rdata 0x1234_5678.
REQ-034 Push 5 commands back-to-back with waitreq high (depth 4) -> ready low after 5th accepted push, subsequent push dropped, responses in order.
REQ-035 Read with rdatavld never asserted -> rsp at TIMEOUT_CYC, timeout 1, rdata 0xFFFF_FFFF, next command then issues.
REQ-036 Command chnl 30 (NUM_CHNL 24) -> no bus activity, timeout response; reset asserted during WAIT_RD -> no response, all outputs 0.

Source files
------------

// File: rtl/aib_avmm_pkg.sv
`default_nettype none
// ============================================================================
// Module : aib_avmm_pkg
// Brief  : Shared types and constants for the AIB AVMM command sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package aib_avmm_pkg;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    localparam logic [DATA_W-1:0] RDATA_ERR = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RSP     = 2'd3
    } state_e;

    // Width-fixed part of a command; channel and address widths are per-instance.
    typedef struct packed {
        logic              write;
        logic [BE_W-1:0]   byte_en;
        logic [DATA_W-1:0] wdata;
    } cmd_attr_t;

endpackage
`default_nettype wire

// File: rtl/aib_avmm_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module : aib_avmm_cmd_seq_if
// Brief  : Command, response and AVMM bus signals of the command sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface aib_avmm_cmd_seq_if #(
    parameter int CHNL_W = 6,
    parameter int ADDR_W = 17
) ();
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic              i_cmd_write;
    logic [CHNL_W-1:0] i_cmd_chnl;
    logic [ADDR_W-1:0] i_cmd_addr;
    logic [3:0]        i_cmd_byte_en;
    logic [31:0]       i_cmd_wdata;

    logic              o_rsp_valid;
    logic [CHNL_W-1:0] o_rsp_chnl;
    logic [31:0]       o_rsp_rdata;
    logic              o_rsp_write;
    logic              o_rsp_timeout;

    logic [CHNL_W-1:0] o_channel_id;
    logic [ADDR_W-1:0] o_cfg_avmm_addr;
    logic [3:0]        o_cfg_avmm_byte_en;
    logic              o_cfg_avmm_read;
    logic              o_cfg_avmm_write;
    logic [31:0]       o_cfg_avmm_wdata;
    logic              i_cfg_avmm_waitreq;
    logic              i_cfg_avmm_rdatavld;
    logic [31:0]       i_cfg_avmm_rdata;

    logic              o_busy;

    // master: the sequencer itself (it masters the AVMM bus); slave: its environment
    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_chnl, i_cmd_addr, i_cmd_byte_en, i_cmd_wdata,
        input  i_cfg_avmm_waitreq, i_cfg_avmm_rdatavld, i_cfg_avmm_rdata,
        output o_cmd_ready, o_rsp_valid, o_rsp_chnl, o_rsp_rdata, o_rsp_write, o_rsp_timeout,
        output o_channel_id, o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_read,
        output o_cfg_avmm_write, o_cfg_avmm_wdata, o_busy
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_chnl, i_cmd_addr, i_cmd_byte_en, i_cmd_wdata,
        output i_cfg_avmm_waitreq, i_cfg_avmm_rdatavld, i_cfg_avmm_rdata,
        input  o_cmd_ready, o_rsp_valid, o_rsp_chnl, o_rsp_rdata, o_rsp_write, o_rsp_timeout,
        input  o_channel_id, o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_read,
        input  o_cfg_avmm_write, o_cfg_avmm_wdata, o_busy
    );
endinterface
`default_nettype wire

// File: rtl/aib_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : aib_sync_fifo
// Brief  : Single-clock FIFO, power-of-2 depth, synchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
module aib_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    input  wire logic             push_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             pop_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             w_push, w_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign full_o   = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign w_push   = push_i && !full_o;
    assign w_pop    = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + (PTR_W+1)'(w_push);
    assign rd_ptr_d = rd_ptr_q + (PTR_W+1)'(w_pop);
    assign data_o   = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aib_avmm_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module : aib_avmm_cmd_seq
// Brief  : Queues AVMM commands per AIB channel and runs them one at a time.
// Rev    : 1.0  initial release
// ============================================================================
module aib_avmm_cmd_seq #(
    parameter int NUM_CHNL    = 24,
    parameter int CHNL_W      = 6,
    parameter int ADDR_W      = 17,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  wire logic         i_cfg_avmm_clk,
    input  wire logic         i_cfg_avmm_rst_n,
    aib_avmm_cmd_seq_if.master bus
);
    import aib_avmm_pkg::*;

    typedef struct packed {
        cmd_attr_t         attr;
        logic [CHNL_W-1:0] chnl;
        logic [ADDR_W-1:0] addr;
    } cmd_t;

    localparam int             CMD_W   = $bits(cmd_t);
    localparam int             TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_e            state_q, state_d;
    cmd_t              cmd_q, cmd_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              tmo_q, tmo_d;

    cmd_t              w_push_cmd, w_head;
    logic              w_full, w_empty, w_pop, w_head_bad, w_last;

    assign w_push_cmd = '{attr: '{write:   bus.i_cmd_write,
                                  byte_en: bus.i_cmd_byte_en,
                                  wdata:   bus.i_cmd_wdata},
                          chnl: bus.i_cmd_chnl,
                          addr: bus.i_cmd_addr};

    aib_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (i_cfg_avmm_clk),
        .rst_ni  (i_cfg_avmm_rst_n),
        .push_i  (bus.i_cmd_valid),
        .data_i  (w_push_cmd),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign w_head_bad = (32'(w_head.chnl) >= NUM_CHNL);
    assign w_last     = (cnt_q == TO_LAST);

    always_ff @(posedge i_cfg_avmm_clk) begin
        if (!i_cfg_avmm_rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        w_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    cmd_d = w_head;
                    cnt_d = '0;
                    // Out-of-range channels never touch the bus.
                    if (w_head_bad) begin
                        state_d = ST_RSP;
                        tmo_d   = 1'b1;
                        rdata_d = RDATA_ERR;
                    end else begin
                        state_d = ST_ISSUE;
                        tmo_d   = 1'b0;
                        rdata_d = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (!bus.i_cfg_avmm_waitreq && cmd_q.attr.write) begin
                    state_d = ST_RSP;
                    rdata_d = '0;
                end else if (w_last) begin
                    state_d = ST_RSP;
                    tmo_d   = 1'b1;
                    rdata_d = RDATA_ERR;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                    if (!bus.i_cfg_avmm_waitreq) begin
                        state_d = ST_WAIT_RD;
                    end
                end
            end
            ST_WAIT_RD: begin
                if (bus.i_cfg_avmm_rdatavld) begin
                    state_d = ST_RSP;
                    rdata_d = bus.i_cfg_avmm_rdata;
                end else if (w_last) begin
                    state_d = ST_RSP;
                    tmo_d   = 1'b1;
                    rdata_d = RDATA_ERR;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus and response fields are forced to zero outside the state that owns them.
    always_comb begin
        bus.o_cmd_ready        = !w_full;
        bus.o_busy             = !w_empty || (state_q != ST_IDLE);
        bus.o_cfg_avmm_read    = 1'b0;
        bus.o_cfg_avmm_write   = 1'b0;
        bus.o_cfg_avmm_addr    = '0;
        bus.o_cfg_avmm_byte_en = '0;
        bus.o_cfg_avmm_wdata   = '0;
        bus.o_channel_id       = '0;
        bus.o_rsp_valid        = 1'b0;
        bus.o_rsp_chnl         = '0;
        bus.o_rsp_rdata        = '0;
        bus.o_rsp_write        = 1'b0;
        bus.o_rsp_timeout      = 1'b0;
        if (state_q == ST_ISSUE) begin
            bus.o_cfg_avmm_read    = !cmd_q.attr.write;
            bus.o_cfg_avmm_write   = cmd_q.attr.write;
            bus.o_cfg_avmm_addr    = cmd_q.addr;
            bus.o_cfg_avmm_byte_en = cmd_q.attr.byte_en;
            bus.o_cfg_avmm_wdata   = cmd_q.attr.wdata;
            bus.o_channel_id       = cmd_q.chnl;
        end
        if (state_q == ST_RSP) begin
            bus.o_rsp_valid   = 1'b1;
            bus.o_rsp_chnl    = cmd_q.chnl;
            bus.o_rsp_rdata   = rdata_q;
            bus.o_rsp_write   = cmd_q.attr.write;
            bus.o_rsp_timeout = tmo_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aib_avmm_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_aib_avmm_cmd_seq
// Brief  : Directed self-checking bench for aib_avmm_cmd_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_aib_avmm_cmd_seq;

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    aib_avmm_cmd_seq_if #(.CHNL_W(6), .ADDR_W(17)) bif ();

    aib_avmm_cmd_seq #(
        .NUM_CHNL    (24),
        .CHNL_W      (6),
        .ADDR_W      (17),
        .CMD_DEPTH   (4),
        .TIMEOUT_CYC (256)
    ) dut (
        .i_cfg_avmm_clk   (clk),
        .i_cfg_avmm_rst_n (rst_n),
        .bus              (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [5:0] ch, input logic [16:0] ad,
                         input logic [31:0] wd);
        bif.i_cmd_valid   = 1'b1;
        bif.i_cmd_write   = w;
        bif.i_cmd_chnl    = ch;
        bif.i_cmd_addr    = ad;
        bif.i_cmd_byte_en = 4'hF;
        bif.i_cmd_wdata   = wd;
    endtask

    task automatic wait_rsp(input int max_cyc, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            tick();
            if (bif.o_rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        logic seen;
        int   n;

        rst_n                   = 1'b0;
        bif.i_cmd_valid         = 1'b0;
        bif.i_cmd_write         = 1'b0;
        bif.i_cmd_chnl          = '0;
        bif.i_cmd_addr          = '0;
        bif.i_cmd_byte_en       = '0;
        bif.i_cmd_wdata         = '0;
        bif.i_cfg_avmm_waitreq  = 1'b0;
        bif.i_cfg_avmm_rdatavld = 1'b0;
        bif.i_cfg_avmm_rdata    = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_ready", bif.o_cmd_ready, 1);
        chk("rst_busy", bif.o_busy, 0);
        chk("rst_rsp_valid", bif.o_rsp_valid, 0);
        chk("rst_read", bif.o_cfg_avmm_read, 0);
        chk("rst_write", bif.o_cfg_avmm_write, 0);
        rst_n = 1'b1;
        tick();

        // Single write, no wait states
        drive(1'b1, 6'd3, 17'h00208, 32'hA5A5_0001);
        tick();
        bif.i_cmd_valid = 1'b0;
        chk("t1_no_early_write", bif.o_cfg_avmm_write, 0);
        chk("t1_busy", bif.o_busy, 1);
        tick();
        chk("t1_write", bif.o_cfg_avmm_write, 1);
        chk("t1_read", bif.o_cfg_avmm_read, 0);
        chk("t1_addr", bif.o_cfg_avmm_addr, 32'h00208);
        chk("t1_wdata", bif.o_cfg_avmm_wdata, 32'hA5A5_0001);
        chk("t1_chnl_id", bif.o_channel_id, 3);
        chk("t1_be", bif.o_cfg_avmm_byte_en, 4'hF);
        tick();
        chk("t1_write_pulse", bif.o_cfg_avmm_write, 0);
        chk("t1_rsp_valid", bif.o_rsp_valid, 1);
        chk("t1_rsp_chnl", bif.o_rsp_chnl, 3);
        chk("t1_rsp_rdata", bif.o_rsp_rdata, 0);
        chk("t1_rsp_tmo", bif.o_rsp_timeout, 0);
        chk("t1_rsp_write", bif.o_rsp_write, 1);
        tick();
        chk("t1_rsp_one_cycle", bif.o_rsp_valid, 0);
        chk("t1_idle", bif.o_busy, 0);

        // Read with three wait-state cycles and late read data
        bif.i_cfg_avmm_waitreq = 1'b1;
        drive(1'b0, 6'd5, 17'h00300, 32'h0);
        tick();
        bif.i_cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t2_read_held", bif.o_cfg_avmm_read, 1);
            chk("t2_addr_held", bif.o_cfg_avmm_addr, 32'h00300);
            bif.i_cfg_avmm_rdatavld = (i == 1);
            bif.i_cfg_avmm_rdata    = (i == 1) ? 32'hDEAD_BEEF : 32'h0;
            if (i == 3) bif.i_cfg_avmm_waitreq = 1'b0;
            tick();
        end
        chk("t2_read_dropped", bif.o_cfg_avmm_read, 0);
        chk("t2_no_early_rsp", bif.o_rsp_valid, 0);
        tick();
        chk("t2_no_rsp_wait", bif.o_rsp_valid, 0);
        bif.i_cfg_avmm_rdatavld = 1'b1;
        bif.i_cfg_avmm_rdata    = 32'h1234_5678;
        tick();
        bif.i_cfg_avmm_rdatavld = 1'b0;
        chk("t2_rsp_valid", bif.o_rsp_valid, 1);
        chk("t2_rsp_rdata", bif.o_rsp_rdata, 32'h1234_5678);
        chk("t2_rsp_write", bif.o_rsp_write, 0);
        chk("t2_rsp_chnl", bif.o_rsp_chnl, 5);
        chk("t2_rsp_tmo", bif.o_rsp_timeout, 0);
        tick();

        // Fill the FIFO while the bus stalls; sixth push is dropped
        bif.i_cfg_avmm_waitreq = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready_before_push", bif.o_cmd_ready, 1);
            drive(1'b1, 6'(i), 17'(i), 32'(i));
            tick();
        end
        chk("t3_ready_full", bif.o_cmd_ready, 0);
        drive(1'b1, 6'd9, 17'h9, 32'h9);
        tick();
        bif.i_cmd_valid = 1'b0;
        chk("t3_still_full", bif.o_cmd_ready, 0);
        bif.i_cfg_avmm_waitreq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_rsp(8, ok);
            chk("t3_rsp_seen", ok, 1);
            chk("t3_rsp_order", bif.o_rsp_chnl, i);
        end
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (bif.o_rsp_valid) seen = 1'b1;
        end
        chk("t3_dropped_no_rsp", seen, 0);
        chk("t3_drained", bif.o_busy, 0);
        chk("t3_ready_again", bif.o_cmd_ready, 1);

        // Read data never returns: timeout, then queued write proceeds
        drive(1'b0, 6'd7, 17'h00040, 32'h0);
        tick();
        drive(1'b1, 6'd8, 17'h00044, 32'h77);
        tick();
        bif.i_cmd_valid = 1'b0;
        chk("t4_read", bif.o_cfg_avmm_read, 1);
        n = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            n++;
            if (bif.o_rsp_valid) break;
        end
        chk("t4_tmo_latency", n, 256);
        chk("t4_rsp_tmo", bif.o_rsp_timeout, 1);
        chk("t4_rsp_rdata", bif.o_rsp_rdata, 32'hFFFF_FFFF);
        chk("t4_rsp_chnl", bif.o_rsp_chnl, 7);
        chk("t4_read_off", bif.o_cfg_avmm_read, 0);
        tick();
        chk("t4_gap", bif.o_cfg_avmm_write, 0);
        tick();
        chk("t4_next_write", bif.o_cfg_avmm_write, 1);
        chk("t4_next_chnl", bif.o_channel_id, 8);
        tick();
        chk("t4_next_rsp", bif.o_rsp_valid, 1);
        chk("t4_next_tmo", bif.o_rsp_timeout, 0);
        chk("t4_next_rsp_write", bif.o_rsp_write, 1);
        tick();

        // Out-of-range channel bypasses the bus
        drive(1'b0, 6'd30, 17'h00010, 32'h0);
        tick();
        bif.i_cmd_valid = 1'b0;
        chk("t5_no_read_idle", bif.o_cfg_avmm_read, 0);
        tick();
        chk("t5_rsp_valid", bif.o_rsp_valid, 1);
        chk("t5_rsp_tmo", bif.o_rsp_timeout, 1);
        chk("t5_rsp_rdata", bif.o_rsp_rdata, 32'hFFFF_FFFF);
        chk("t5_rsp_chnl", bif.o_rsp_chnl, 30);
        chk("t5_no_read", bif.o_cfg_avmm_read, 0);
        chk("t5_no_write", bif.o_cfg_avmm_write, 0);
        tick();
        chk("t5_idle", bif.o_busy, 0);

        // Reset during WAIT_RD discards in-flight and queued commands
        drive(1'b0, 6'd2, 17'h00020, 32'h0);
        tick();
        drive(1'b1, 6'd4, 17'h00024, 32'h55);
        tick();
        bif.i_cmd_valid = 1'b0;
        tick();
        chk("t6_wait_rd_read", bif.o_cfg_avmm_read, 0);
        chk("t6_wait_rd_busy", bif.o_busy, 1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_rsp_valid", bif.o_rsp_valid, 0);
        chk("t6_rst_busy", bif.o_busy, 0);
        chk("t6_rst_read", bif.o_cfg_avmm_read, 0);
        chk("t6_rst_write", bif.o_cfg_avmm_write, 0);
        chk("t6_rst_addr", bif.o_cfg_avmm_addr, 0);
        chk("t6_rst_chnl_id", bif.o_channel_id, 0);
        chk("t6_rst_rdata", bif.o_rsp_rdata, 0);
        chk("t6_rst_tmo", bif.o_rsp_timeout, 0);
        chk("t6_rst_ready", bif.o_cmd_ready, 1);
        rst_n                   = 1'b1;
        bif.i_cfg_avmm_rdatavld = 1'b1;
        bif.i_cfg_avmm_rdata    = 32'hCAFE_F00D;
        tick();
        bif.i_cfg_avmm_rdatavld = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (bif.o_rsp_valid || bif.o_cfg_avmm_write || bif.o_cfg_avmm_read) seen = 1'b1;
            tick();
        end
        chk("t6_post_rst_quiet", seen, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
